// File: rtl/led_fade_pwm_if.sv
`timescale 1ns/1ps
// LED pattern in / PWM drive out between the chaser and the fade stage.
interface led_fade_pwm_if;
   logic [7:0] iLED;
   logic [7:0] oLED;

   modport master (output iLED, input oLED);
   modport slave  (input iLED, output oLED);
endinterface

// File: rtl/led_fade_pwm.sv
`timescale 1ns/1ps
// Afterglow stage: resyncs the chaser pattern, decays unlit channel brightness on a shared tick
// and PWM-drives oLED from a shared counter. iLED to oLED rise latency <= 4 cycles.
module led_fade_pwm #(
   parameter int PWM_W      = 8,
   parameter int DECAY_DIV  = 50000,
   parameter int DECAY_STEP = 16
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   led_fade_pwm_if.slave    led_if
);

   localparam int               DIV_W   = $clog2(DECAY_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DECAY_DIV - 1);
   localparam logic [PWM_W-1:0] FULL    = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0] STEP    = PWM_W'(DECAY_STEP);

   logic [7:0]       sync1_q, sync1_d;
   logic [7:0]       sync2_q, sync2_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic [PWM_W-1:0] bri_q [8];
   logic [PWM_W-1:0] bri_d [8];
   logic [7:0]       led_q, led_d;
   logic             tick;

   always_comb begin
      sync1_d = led_if.iLED;
      sync2_d = sync1_q;
      tick    = (div_q == DIV_MAX);
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      pwm_d   = pwm_q + PWM_W'(1);
      led_d   = '0;
      for (int i = 0; i < 8; i++) begin
         // Lit overrides a coincident tick; decay saturates at zero.
         if (sync2_q[i])
            bri_d[i] = FULL;
         else if (tick)
            bri_d[i] = (bri_q[i] > STEP) ? bri_q[i] - STEP : '0;
         else
            bri_d[i] = bri_q[i];
         // Full scale is forced high so there is no one-count dark gap per period.
         led_d[i] = (bri_q[i] == FULL) | (bri_q[i] > pwm_q);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         div_q   <= '0;
         pwm_q   <= '0;
         led_q   <= '0;
         for (int i = 0; i < 8; i++) bri_q[i] <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         div_q   <= div_d;
         pwm_q   <= pwm_d;
         led_q   <= led_d;
         for (int i = 0; i < 8; i++) bri_q[i] <= bri_d[i];
      end
   end

   assign led_if.oLED = led_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
`timescale 1ns/1ps
// Directed checks of led_fade_pwm: two fast-decay instances (step 64 and 200) and a
// slow-decay instance whose brightness levels last long enough to measure PWM duty.
module tb_led_fade_pwm;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] led_in;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   always #5 clk = ~clk;

   led_fade_pwm_if if_a ();
   led_fade_pwm_if if_b ();
   led_fade_pwm_if if_c ();

   led_fade_pwm #(.PWM_W(8), .DECAY_DIV(4),    .DECAY_STEP(64))  u_a (.iCLK(clk), .iRST_n(rst_n), .led_if(if_a));
   led_fade_pwm #(.PWM_W(8), .DECAY_DIV(4),    .DECAY_STEP(200)) u_b (.iCLK(clk), .iRST_n(rst_n), .led_if(if_b));
   led_fade_pwm #(.PWM_W(8), .DECAY_DIV(1024), .DECAY_STEP(64))  u_c (.iCLK(clk), .iRST_n(rst_n), .led_if(if_c));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_led(input logic [7:0] v);
      led_in    = v;
      if_a.iLED = v;
      if_b.iLED = v;
      if_c.iLED = v;
   endtask

   initial begin
      int bad, bad2, bad3, cnt;
      logic [7:0] h1, h2, h3, mask, prev_bri [8];
      int p, pp, lit;

      // ---- reset state and async reset mid-run ----
      rst_n = 1'b0;
      set_led(8'h00);
      repeat (3) @(negedge clk);
      check("rst_oled", int'(if_a.oLED), 0);
      check("rst_bri0", int'(u_a.bri_q[0]), 0);
      set_led(8'hFF);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("run_all_on", int'(if_a.oLED), 8'hFF);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("rst_async_drop", int'(if_a.oLED), 0);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (if_a.oLED !== 8'h00) bad++;
      end
      check("rst_hold_zero", bad, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("release_edge3", int'(if_a.oLED), 0);
      @(negedge clk);
      check("release_edge4", int'(if_a.oLED), 8'hFF);

      // ---- full-on latency and constant-high full scale ----
      set_led(8'h00);
      repeat (40) @(negedge clk);
      check("dark_after_fade", int'(if_a.oLED), 0);
      set_led(8'h01);
      repeat (3) @(negedge clk);
      check("on_edge3_dark", int'(if_a.oLED), 0);
      @(negedge clk);
      check("on_edge4_lit", int'(if_a.oLED), 8'h01);
      cnt = 0; bad = 0;
      repeat (256) begin
         @(negedge clk);
         if (if_a.oLED[0] === 1'b1) cnt++;
         if (if_a.oLED[7:1] !== 7'h00) bad++;
      end
      check("full_on_hi_cnt", cnt, 256);
      check("full_on_others", bad, 0);

      // ---- fade sequence, saturation and measured duty ----
      set_led(8'h02);
      fork
         begin
            automatic logic [7:0] last = 8'd255;
            repeat (40) begin
               @(negedge clk);
               if (u_a.bri_q[0] != last) begin
                  last = u_a.bri_q[0];
                  qa.push_back(last);
               end
            end
         end
         begin
            automatic logic [7:0] last = 8'd255;
            repeat (40) begin
               @(negedge clk);
               if (u_b.bri_q[0] != last) begin
                  last = u_b.bri_q[0];
                  qb.push_back(last);
               end
            end
         end
         begin
            automatic int lv[4] = '{191, 127, 63, 0};
            automatic int cur = 255;
            for (int k = 0; k < 4; k++) begin
               automatic int to = 1;
               automatic int hi = 0;
               for (int w = 0; w < 1500; w++) begin
                  @(negedge clk);
                  if (int'(u_c.bri_q[0]) != cur) begin
                     to = 0;
                     break;
                  end
               end
               check("c_tick_wait_timeout", to, 0);
               if (to != 0) break;
               cur = int'(u_c.bri_q[0]);
               check("c_bri_level", cur, lv[k]);
               repeat (256) begin
                  @(negedge clk);
                  if (if_c.oLED[0] === 1'b1) hi++;
               end
               check("c_duty_hi_cnt", hi, lv[k]);
            end
         end
      join
      check("a_seq_len", qa.size(), 4);
      if (qa.size() == 4) begin
         check("a_seq_191", int'(qa[0]), 191);
         check("a_seq_127", int'(qa[1]), 127);
         check("a_seq_63",  int'(qa[2]), 63);
         check("a_seq_0",   int'(qa[3]), 0);
      end
      check("b_sat_len", qb.size(), 2);
      if (qb.size() == 2) begin
         check("b_sat_55", int'(qb[0]), 55);
         check("b_sat_0",  int'(qb[1]), 0);
      end
      cnt = 0;
      repeat (256) begin
         @(negedge clk);
         if (if_a.oLED[0] !== 1'b0) cnt++;
      end
      check("a_faded_off_cnt", cnt, 0);

      // ---- lit beats decay over many ticks ----
      set_led(8'h08);
      repeat (4) @(negedge clk);
      bad = 0; bad2 = 0;
      repeat (60) begin
         @(negedge clk);
         if (u_a.bri_q[3] != 8'd255) bad++;
         if (if_a.oLED[3] !== 1'b1) bad2++;
      end
      check("lit_bri_not_full", bad, 0);
      check("lit_oled_zero", bad2, 0);

      // ---- chaser walk: trail shape and no rise while unlit ----
      bad = 0; bad2 = 0; bad3 = 0;
      h1 = led_in; h2 = led_in; h3 = led_in;
      for (int i = 0; i < 8; i++) prev_bri[i] = u_a.bri_q[i];
      p = 3;
      for (int s = 0; s < 9; s++) begin
         lit = s % 8;
         set_led(8'h01 << lit);
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            mask = led_in | h1 | h2 | h3;
            for (int i = 0; i < 8; i++) begin
               if (!mask[i] && (u_a.bri_q[i] > prev_bri[i])) bad3++;
               prev_bri[i] = u_a.bri_q[i];
            end
            h3 = h2; h2 = h1; h1 = led_in;
            if (c == 9) begin
               automatic int nz = 0;
               pp = (p + 7) % 8;
               if (!(u_a.bri_q[p] > 8'd0 && u_a.bri_q[p] < 8'd255 && u_a.bri_q[p] > u_a.bri_q[pp])) bad++;
               for (int i = 0; i < 8; i++)
                  if (i != lit && u_a.bri_q[i] != 8'd0) nz++;
               if (nz > 4) bad2++;
            end
         end
         p = lit;
      end
      check("chase_trail_decreasing", bad, 0);
      check("chase_trail_count", bad2, 0);
      check("chase_no_rise_unlit", bad3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
